// File: rtl/dram_port_arbiter_pkg.sv
// Shared constants for the DRAM port arbiter: FSM encodings, default bus widths
// and the core-id width.
package dram_arb_pkg;

  localparam int DEF_N_CORES = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 8;
  localparam int CORE_ID_W   = $clog2(DEF_N_CORES);

  // state | meaning
  // IDLE  | arbitrate among pending requests, latch the winner
  // ISSUE | DRAM address/data/enable driven for exactly one cycle
  // WAIT  | read in flight, count down DRAM latency
  // RESP  | one-cycle ack to the winner, pointer advances
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Bundle of the per-core request/response buses and the DRAM macro pins.
// slave: the arbiter; master: the core array plus DRAM macro side.
interface dram_port_arbiter_if
  import dram_arb_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [N_CORES-1:0]        i_rd;
  logic [N_CORES-1:0]        i_wr;
  logic [N_CORES*ADDR_W-1:0] i_addr;
  logic [N_CORES*DATA_W-1:0] i_wdata;
  logic [N_CORES*DATA_W-1:0] o_rdata;
  logic [N_CORES-1:0]        o_ack;
  logic [ADDR_W-1:0]         o_mem_addr;
  logic [DATA_W-1:0]         o_mem_wdata;
  logic                      o_mem_rden;
  logic                      o_mem_wren;
  logic [DATA_W-1:0]         i_mem_q;

  modport slave (
    input  i_rd, i_wr, i_addr, i_wdata, i_mem_q,
    output o_rdata, o_ack, o_mem_addr, o_mem_wdata, o_mem_rden, o_mem_wren
  );

  modport master (
    output i_rd, i_wr, i_addr, i_wdata, i_mem_q,
    input  o_rdata, o_ack, o_mem_addr, o_mem_wdata, o_mem_rden, o_mem_wren
  );

endinterface

// File: rtl/dram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward with wrap and
// returns a one-hot grant plus the encoded winner id.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id
);

  // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    grant = '0;
    id    = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant = '0;
        grant[(int'(ptr) + i) % N] = 1'b1;
        id = ID_W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Serialises per-core DRAM read/write requests onto one single-port synchronous
// DRAM with round-robin fairness. All outputs come straight from flops.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int N_CORES     = DEF_N_CORES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LATENCY = 2
) (
  input logic i_clk,
  input logic i_rst,
  dram_port_arbiter_if.slave bus
);

  localparam int ID_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [1:0]                state;
  logic [ID_W-1:0]           ptr;
  logic [ID_W-1:0]           win_id;
  logic                      win_wr;
  logic [2:0]                cnt;
  logic [N_CORES-1:0]        req_arb;
  logic [N_CORES-1:0]        gnt;
  logic [ID_W-1:0]           gnt_id;
  logic [N_CORES-1:0]        ack_q;
  logic [N_CORES*DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0]         mem_addr_q;
  logic [DATA_W-1:0]         mem_wdata_q;
  logic                      mem_rden_q;
  logic                      mem_wren_q;

  // Arbiter only sees requests while idle, so grants never shift mid-transaction.
  always_comb begin
    req_arb = (state == IDLE) ? (bus.i_rd | bus.i_wr) : '0;
  end

  rr_arbiter #(
    .N    (N_CORES),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .req   (req_arb),
    .ptr   (ptr),
    .grant (gnt),
    .id    (gnt_id)
  );

  // Transaction sequencer; the DRAM address/data registers double as the
  // request latch, so they simply hold until the next grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      ptr         <= ID_W'(N_CORES - 1);
      win_id      <= '0;
      win_wr      <= 1'b0;
      cnt         <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rden_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (|req_arb) begin
            // A write wins over a simultaneous read on the same core.
            win_id      <= gnt_id;
            win_wr      <= |(gnt & bus.i_wr);
            mem_addr_q  <= bus.i_addr[gnt_id*ADDR_W +: ADDR_W];
            mem_wdata_q <= bus.i_wdata[gnt_id*DATA_W +: DATA_W];
            mem_wren_q  <= |(gnt & bus.i_wr);
            mem_rden_q  <= ~(|(gnt & bus.i_wr));
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mem_rden_q <= 1'b0;
          mem_wren_q <= 1'b0;
          if (win_wr) begin
            ack_q[win_id] <= 1'b1;
            state         <= RESP;
          end else begin
            cnt   <= 3'(MEM_LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rdata_q[win_id*DATA_W +: DATA_W] <= bus.i_mem_q;
            ack_q[win_id] <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          ptr   <= win_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ack       = ack_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_rden  = mem_rden_q;
  assign bus.o_mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a small DRAM model (2-cycle read).
module tb_dram_port_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   rden_cnt;
  int   wren_cnt;
  int   viol;
  int   order_q[$];
  int   when_q[$];

  dram_port_arbiter_if #(.N_CORES(4), .ADDR_W(16), .DATA_W(8)) bus ();

  dram_port_arbiter #(
    .N_CORES     (4),
    .ADDR_W      (16),
    .DATA_W      (8),
    .MEM_LATENCY (2)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model: write on wren, read data valid two cycles after the rden cycle
  logic [7:0] mem [0:65535];
  logic [7:0] stage1;
  always @(posedge clk) begin
    if (bus.o_mem_wren) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
    if (bus.o_mem_rden) stage1 <= mem[bus.o_mem_addr];
    bus.i_mem_q <= stage1;
  end

  // Pulse counters and exclusivity monitor
  always @(negedge clk) begin
    if (bus.o_mem_rden) rden_cnt++;
    if (bus.o_mem_wren) wren_cnt++;
    if ((bus.o_mem_rden && bus.o_mem_wren) || !$onehot0(bus.o_ack)) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One request on core k; returns one idle cycle after the ack.
  task automatic xact(input int k, input logic rd, input logic wr, input logic [15:0] a,
                      input logic [7:0] d, input int exp_lat, input string tag);
    int n;
    bus.i_rd[k] = rd;
    bus.i_wr[k] = wr;
    bus.i_addr[k*16 +: 16] = a;
    bus.i_wdata[k*8 +: 8]  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, " issue addr"}, bus.o_mem_addr, a);
        chk({tag, " issue wren"}, bus.o_mem_wren, wr);
        chk({tag, " issue rden"}, bus.o_mem_rden, rd & ~wr);
        if (wr) chk({tag, " issue wdata"}, bus.o_mem_wdata, d);
      end
    end while (bus.o_ack == 4'b0 && n < 20);
    chk({tag, " ack"}, bus.o_ack, 4'b1 << k);
    chk({tag, " latency"}, n, exp_lat);
    bus.i_rd[k] = 1'b0;
    bus.i_wr[k] = 1'b0;
    @(negedge clk);
  endtask

  // Record acks of concurrently pending requests. A core in hold keeps its
  // request through its first ack; otherwise it drops at the ack cycle.
  task automatic collect(input logic [3:0] hold_in, input int max_acks, input int budget);
    logic [3:0] hold;
    hold = hold_in;
    order_q.delete();
    when_q.delete();
    for (int n = 1; n <= budget && order_q.size() < max_acks; n++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (bus.o_ack[k]) begin
          order_q.push_back(k);
          when_q.push_back(n);
          if (hold[k]) hold[k] = 1'b0;
          else begin
            bus.i_rd[k] = 1'b0;
            bus.i_wr[k] = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_seq(input string tag, input int n, input int ids[4], input int whens[4]);
    chk({tag, " count"}, order_q.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s id%0d", tag, i), (i < order_q.size()) ? order_q[i] : 99, ids[i]);
      chk($sformatf("%s t%0d", tag, i), (i < when_q.size()) ? when_q[i] : 99, whens[i]);
    end
  endtask

  initial begin
    int idle_bad;
    int r0;
    int w0;
    tests = 0; failed = 0; rden_cnt = 0; wren_cnt = 0; viol = 0;
    rst = 1'b1;
    bus.i_rd = '0; bus.i_wr = '0; bus.i_addr = '0; bus.i_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset ack", bus.o_ack, 4'b0);
    chk("reset rden", bus.o_mem_rden, 1'b0);
    chk("reset wren", bus.o_mem_wren, 1'b0);
    chk("reset rdata", bus.o_rdata, 32'h0);
    chk("reset addr", bus.o_mem_addr, 16'h0);
    chk("reset wdata", bus.o_mem_wdata, 8'h0);

    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_ack != 0 || bus.o_mem_rden || bus.o_mem_wren || bus.o_rdata != 0) idle_bad++;
    end
    chk("idle 20 cycles", idle_bad, 0);

    // Single write then read on core 2
    xact(2, 1'b0, 1'b1, 16'h1234, 8'hA5, 2, "c2 write");
    xact(2, 1'b1, 1'b0, 16'h1234, 8'h00, 4, "c2 read");
    chk("c2 read rdata", bus.o_rdata, 32'h00A5_0000);

    // Preload distinct addresses, ending on core 3 so core 0 is next in line
    xact(0, 1'b0, 1'b1, 16'h0100, 8'h11, 2, "pre c0");
    xact(1, 1'b0, 1'b1, 16'h0201, 8'h22, 2, "pre c1");
    xact(2, 1'b0, 1'b1, 16'h0403, 8'h44, 2, "pre c2");
    xact(3, 1'b0, 1'b1, 16'h0302, 8'h33, 2, "pre c3");

    // All four read at once
    bus.i_addr = {16'h0302, 16'h0403, 16'h0201, 16'h0100};
    bus.i_rd = 4'b1111;
    collect(4'b0000, 4, 40);
    chk_seq("all rd", 4, '{0, 1, 2, 3}, '{4, 9, 14, 19});
    chk("all rd rdata", bus.o_rdata, 32'h3344_2211);

    // Wrap: core 3 just served, cores 0 and 3 request together
    bus.i_addr = {16'h0302, 16'h0, 16'h0, 16'h0100};
    bus.i_rd = 4'b1001;
    collect(4'b0000, 2, 30);
    chk_seq("wrap", 2, '{0, 3, 0, 0}, '{4, 9, 0, 0});

    // Read and write together on core 1: write only
    r0 = rden_cnt; w0 = wren_cnt;
    xact(1, 1'b1, 1'b1, 16'h0555, 8'h3C, 2, "c1 rdwr");
    chk("c1 rdwr wren pulses", wren_cnt - w0, 1);
    chk("c1 rdwr rden pulses", rden_cnt - r0, 0);
    chk("c1 rdwr rdata kept", bus.o_rdata, 32'h3344_2211);
    xact(1, 1'b1, 1'b0, 16'h0555, 8'h00, 4, "c1 readback");
    chk("c1 readback rdata", bus.o_rdata, 32'h3344_3C11);

    // Core 0 holds its request past the ack while core 1 waits
    bus.i_addr = {16'h0, 16'h0, 16'h0601, 16'h0600};
    bus.i_wdata = {8'h0, 8'h0, 8'h6B, 8'h5A};
    bus.i_wr = 4'b0011;
    collect(4'b0001, 3, 20);
    chk_seq("hold", 3, '{0, 1, 0, 0}, '{2, 5, 8, 0});
    idle_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_ack != 0) idle_bad++;
    end
    chk("hold no extra ack", idle_bad, 0);

    // Reset in the middle of a read on core 2
    bus.i_addr[2*16 +: 16] = 16'h1234;
    bus.i_rd[2] = 1'b1;
    @(negedge clk);
    chk("rst-mid rden", bus.o_mem_rden, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus.i_rd = '0;
    @(negedge clk);
    chk("rst-mid ack", bus.o_ack, 4'b0);
    chk("rst-mid rden low", bus.o_mem_rden, 1'b0);
    chk("rst-mid wren low", bus.o_mem_wren, 1'b0);
    chk("rst-mid rdata", bus.o_rdata, 32'h0);
    rst = 1'b0;
    bus.i_addr = {16'h0703, 16'h0, 16'h0, 16'h0700};
    bus.i_wdata = {8'h7A, 8'h0, 8'h0, 8'h77};
    bus.i_wr = 4'b1001;
    collect(4'b0000, 2, 20);
    chk_seq("after rst", 2, '{0, 3, 0, 0}, '{2, 5, 0, 0});

    chk("rden/wren excl, ack onehot", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Memory-side responder for the per-core DRAM request interface. Four cores raise independent read/write requests, and this block serialises them onto one single-port synchronous DRAM using round-robin arbitration. It returns read data and a one-cycle acknowledge to the requesting core only. It sits between the core array and the DRAM macro in the top level.

## Interface
Parameters:
- N_CORES, 4, number of requesting cores
- ADDR_W, 16, DRAM address width
- DATA_W, 8, DRAM word width
- MEM_LATENCY, 2, cycles from rden-high to valid i_mem_q (1..4)

Ports (per-core buses are flat, core k at bits [k*W +: W]):
- i_clk  in  1  system clock; one clock domain
- i_rst  in  1  reset; synchronous, active-high
- i_rd  in  N_CORES  read request per core, held until ack
- i_wr  in  N_CORES  write request per core, held until ack
- i_addr  in  N_CORES*ADDR_W  request address per core
- i_wdata  in  N_CORES*DATA_W  write data per core
- o_rdata  out  N_CORES*DATA_W  read data per core, registered
- o_ack  out  N_CORES  one-cycle completion pulse per core
- o_mem_addr  out  ADDR_W  DRAM address
- o_mem_wdata  out  DATA_W  DRAM write data
- o_mem_rden  out  1  DRAM read enable
- o_mem_wren  out  1  DRAM write enable
- i_mem_q  in  DATA_W  DRAM read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req[k] = i_rd[k] | i_wr[k].
  - If any req is set, pick the winner round-robin, searching from ptr+1 upward with wrap.
  - Latch winner id, op, address and wdata, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly one cycle): drive o_mem_addr/o_mem_wdata from the latch and assert the matching enable.
  - Write: go to RESP.
  - Read: load cnt = MEM_LATENCY, go to WAIT.
- WAIT: decrement cnt each cycle. On the cycle cnt==1, capture i_mem_q into o_rdata[winner] and go to RESP.
- RESP (one cycle): o_ack[winner]=1, set ptr <= winner, go to IDLE.
- Requester rule: the core drops its request at the clock edge that ends its ack cycle. A request still high in the following IDLE is treated as a new request.
- Both i_rd[k] and i_wr[k] set: a write is performed, the read is ignored, and one ack is issued.
- Request changes after latch (address, data, deassert) are ignored until RESP. The transaction always completes.
- o_rdata[k] holds its value until the next read completes for core k. Writes never alter o_rdata.
- At most one o_ack bit is high in any cycle. o_mem_rden and o_mem_wren are never high together.

## Timing
- Reset values: state=IDLE, ptr=N_CORES-1 (core 0 has first priority), o_ack=0, o_mem_rden=0, o_mem_wren=0, o_mem_addr=0, o_mem_wdata=0, o_rdata all 0.
- i_rst asserted mid-transaction aborts it at the next edge: no ack, enables low, state and pointer reset. A write already in ISSUE may have reached DRAM.
- Write latency: request seen in IDLE at cycle c, wren at c+1, ack at c+2. Occupancy is 3 cycles.
- Read latency: rden at c+1, capture at c+1+MEM_LATENCY, ack at c+2+MEM_LATENCY. With default parameters the ack arrives at c+4 and the rdata is valid in the same cycle.
- Back-to-back: IDLE after RESP re-arbitrates immediately. Sustained throughput is one write per 3 cycles or one read per 3+MEM_LATENCY cycles.
- Fairness: with all cores requesting continuously, the grant order is 0,1,2,3,0,… Each core waits at most N_CORES-1 transactions.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package dram_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - ADDR_W / DATA_W defaults
  - core-id width constant $clog2(N_CORES)
- Sub-module rr_arbiter (N parameter):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and encoded id; purely combinational.
  - Instantiated once and evaluated only in IDLE.

## Test plan
- Reset then idle: no requests for 20 cycles -> o_ack=0, enables low, o_rdata all 0; assert i_rst mid-read -> no ack, FSM back in IDLE next cycle.
- Single write then read: core 2 writes 0xA5 to 0x1234, then reads 0x1234 -> write ack at c+2, read ack at c+4, o_rdata[2]=0xA5, other o_rdata unchanged.
- All four cores read simultaneously, each from a distinct preloaded address -> acks in order 0,1,2,3, spaced 5 cycles apart, each core receiving its own data.
- Round-robin wrap: after core 3 is served, cores 0 and 3 request together -> core 0 is granted first.
- Simultaneous rd and wr on core 1 with wdata 0x3C -> one wren pulse, no rden, one ack, memory at that address reads back 0x3C.
- Request held one cycle past ack on core 0 while core 1 also requests -> core 1 is served next, then core 0 again, with no duplicate ack inside a single transaction.
